mc_controller: RTL and testbench
================================

MC_CONTROLLER -- requirements
Module: mc_controller

Interface
REQ-001 SHALL have parameter TIMEOUT, default 15: maximum consecutive memory-wait cycles before ERROR; 0 disables timeout.
REQ-002 SHALL have parameter CNT_W, default 32: width of retired-instruction counter.
REQ-003 SHALL have ports: clk input 1, rising-edge clock; reset input 1, synchronous active-high reset.
REQ-004 SHALL have ports: op input 6, opcode from instruction register; mem_ready input 1, memory handshake completion.
REQ-005 SHALL have ports: mem_req, iord, memwrite, irwrite, pcwrite, branch, alusrca, regdst, memtoreg, regwrite, output 1 each, datapath controls.
REQ-006 SHALL have ports: alusrcb, pcsrc, aluop output 2 each; state output 4, current state; err output 1, sticky fault; retired output CNT_W, instruction count.

Function
REQ-007 SHALL be a Moore FSM with states FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTE, ALUWB, BRANCH, ADDIEXEC, ADDIWB, JUMP, ERROR; encodings 0-12 in that order, driven on state.
REQ-008 Outputs not listed for a state SHALL be 0.
REQ-009 FETCH: mem_req=1, alusrcb=01; irwrite=pcwrite=mem_ready (combinational, same cycle).
REQ-010 DECODE: alusrcb=11. MEMADR and ADDIEXEC: alusrca=1, alusrcb=10.
REQ-011 MEMREAD: iord=1, mem_req=1. MEMWRITE: iord=1, mem_req=1, memwrite=1 for every wait cycle.
REQ-012 MEMWB: memtoreg=1, regwrite=1. ALUWB: regdst=1, regwrite=1. ADDIWB: regwrite=1.
REQ-013 EXECUTE: alusrca=1, aluop=10. BRANCH: alusrca=1, aluop=01, pcsrc=01, branch=1. JUMP: pcsrc=10, pcwrite=1.
REQ-014 ERROR: all controls 0, err=1; exits only via reset.
REQ-015 FETCH->DECODE, MEMREAD->MEMWB, MEMWRITE->FETCH only on a cycle with mem_ready=1; otherwise state holds.
REQ-016 DECODE: op 100011 or 101011->MEMADR; 000000->EXECUTE; 000100->BRANCH; 001000->ADDIEXEC; 000010->JUMP (see REQ-024); any other->ERROR.
REQ-017 MEMADR: op 100011->MEMREAD, else MEMWRITE. EXECUTE->ALUWB; ADDIEXEC->ADDIWB; MEMWB, ALUWB, ADDIWB, BRANCH, JUMP->FETCH.
REQ-018 Wait counter SHALL count consecutive cycles in FETCH/MEMREAD/MEMWRITE with mem_ready=0, clearing on any state change or mem_ready=1.
REQ-019 When TIMEOUT>0 and the wait counter equals TIMEOUT with mem_ready still 0, next state SHALL be ERROR; mem_ready=1 on that same cycle wins (normal transition).
REQ-020 retired SHALL increment by 1 on each transition into FETCH from a non-FETCH, non-ERROR state; wraps modulo 2^CNT_W.
REQ-021 Latency: R-type 4, addi 4, beq 3, lw 5, sw 4, j 3 cycles with mem_ready held 1.

Reset
REQ-022 On reset=1 at a clk edge: state=FETCH, wait counter=0, retired=0, err=0; reset overrides all transitions including from ERROR and mid-wait.
REQ-023 While reset is asserted, outputs SHALL reflect FETCH (mem_req=1, alusrcb=01).

Configuration
REQ-024 Macro MC_CONTROLLER_JUMP_EN defined: op 000010 in DECODE->JUMP. Undefined: JUMP state unreachable, op 000010->ERROR, encoding 11 unused.

Verification
REQ-025 Reset, op=000000, mem_ready=1 -> states 0,1,6,7,0; regwrite=1 and regdst=1 only in ALUWB; retired=1.
REQ-026 op=100011, mem_ready low 3 cycles in MEMREAD -> MEMREAD held 4 cycles, iord=1 throughout, then MEMWB with memtoreg=1.
REQ-027 TIMEOUT=15, mem_ready=0 in FETCH -> ERROR after 16 FETCH cycles, err=1; reset -> FETCH, err=0, retired=0.
REQ-028 op=111111 in DECODE -> ERROR next cycle, retired unchanged.
REQ-029 op=000010 with macro -> 0,1,11,0, pcwrite=1 and pcsrc=10 in JUMP; without macro -> ERROR.
REQ-030 CNT_W=4, 16 beq instructions -> retired wraps 15->0.

Source files
------------

// File: rtl/mc_controller.sv
// Multi-cycle MIPS-style control FSM with memory-wait timeout and a retired-instruction counter.
// Build option: define MC_CONTROLLER_JUMP_EN to decode op 000010 as a jump; otherwise it faults.
module mc_controller #(
   parameter int TIMEOUT = 15,
   parameter int CNT_W   = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [5:0]       op,
   input  logic             mem_ready,
   output logic             mem_req,
   output logic             iord,
   output logic             memwrite,
   output logic             irwrite,
   output logic             pcwrite,
   output logic             branch,
   output logic             alusrca,
   output logic             regdst,
   output logic             memtoreg,
   output logic             regwrite,
   output logic [1:0]       alusrcb,
   output logic [1:0]       pcsrc,
   output logic [1:0]       aluop,
   output logic [3:0]       state,
   output logic             err,
   output logic [CNT_W-1:0] retired
);

   typedef enum logic [3:0] {
      FETCH    = 4'd0,
      DECODE   = 4'd1,
      MEMADR   = 4'd2,
      MEMREAD  = 4'd3,
      MEMWB    = 4'd4,
      MEMWRITE = 4'd5,
      EXECUTE  = 4'd6,
      ALUWB    = 4'd7,
      BRANCH   = 4'd8,
      ADDIEXEC = 4'd9,
      ADDIWB   = 4'd10,
      JUMP     = 4'd11,
      ERROR    = 4'd12
   } state_t;

   typedef struct packed {
      logic       mem_req;
      logic       iord;
      logic       memwrite;
      logic       fetch;
      logic       pcwrite;
      logic       branch;
      logic       alusrca;
      logic       regdst;
      logic       memtoreg;
      logic       regwrite;
      logic       err;
      logic [1:0] alusrcb;
      logic [1:0] pcsrc;
      logic [1:0] aluop;
   } ctrl_t;

   localparam int WAIT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

   state_t            cur;
   state_t            nxt;
   ctrl_t             ctrl;
   logic [WAIT_W-1:0] wait_cnt;
   logic              waiting;
   logic              timed_out;

   function automatic ctrl_t decode_ctrl(input state_t s);
      ctrl_t c;
      c = '0;
      case (s)
         FETCH:    begin c.mem_req = 1'b1; c.fetch = 1'b1; c.alusrcb = 2'b01; end
         DECODE:   c.alusrcb = 2'b11;
         MEMADR,
         ADDIEXEC: begin c.alusrca = 1'b1; c.alusrcb = 2'b10; end
         MEMREAD:  begin c.iord = 1'b1; c.mem_req = 1'b1; end
         MEMWRITE: begin c.iord = 1'b1; c.mem_req = 1'b1; c.memwrite = 1'b1; end
         MEMWB:    begin c.memtoreg = 1'b1; c.regwrite = 1'b1; end
         ALUWB:    begin c.regdst = 1'b1; c.regwrite = 1'b1; end
         ADDIWB:   c.regwrite = 1'b1;
         EXECUTE:  begin c.alusrca = 1'b1; c.aluop = 2'b10; end
         BRANCH:   begin
            c.alusrca = 1'b1;
            c.aluop   = 2'b01;
            c.pcsrc   = 2'b01;
            c.branch  = 1'b1;
         end
         JUMP:     begin c.pcsrc = 2'b10; c.pcwrite = 1'b1; end
         ERROR:    c.err = 1'b1;
         default:  c = '0;
      endcase
      return c;
   endfunction

   // mem_ready is a one-cycle completion strobe: a memory state (FETCH, MEMREAD,
   // MEMWRITE) keeps its request up and holds until it sees mem_ready=1 on a rising edge.
   assign waiting   = ((cur == FETCH) || (cur == MEMREAD) || (cur == MEMWRITE)) && !mem_ready;
   assign timed_out = (TIMEOUT > 0) && waiting && (int'(wait_cnt) == TIMEOUT);

   always_comb begin
      nxt = cur;
      case (cur)
         FETCH:    if (mem_ready) nxt = DECODE;
         DECODE: begin
            case (op)
               6'b100011, 6'b101011: nxt = MEMADR;
               6'b000000:            nxt = EXECUTE;
               6'b000100:            nxt = BRANCH;
               6'b001000:            nxt = ADDIEXEC;
`ifdef MC_CONTROLLER_JUMP_EN
               6'b000010:            nxt = JUMP;
`endif
               default:              nxt = ERROR;
            endcase
         end
         MEMADR:   nxt = (op == 6'b100011) ? MEMREAD : MEMWRITE;
         MEMREAD:  if (mem_ready) nxt = MEMWB;
         MEMWRITE: if (mem_ready) nxt = FETCH;
         EXECUTE:  nxt = ALUWB;
         ADDIEXEC: nxt = ADDIWB;
         MEMWB, ALUWB, ADDIWB, BRANCH, JUMP: nxt = FETCH;
         ERROR:    nxt = ERROR;
         default:  nxt = ERROR;
      endcase
      if (timed_out) nxt = ERROR;
   end

   // Controls are registered from the next state so they line up with the state register.
   always_ff @(posedge clk) begin
      if (reset) begin
         cur      <= FETCH;
         ctrl     <= decode_ctrl(FETCH);
         wait_cnt <= '0;
         retired  <= '0;
      end else begin
         cur      <= nxt;
         ctrl     <= decode_ctrl(nxt);
         wait_cnt <= (waiting && (nxt == cur)) ? wait_cnt + 1'b1 : '0;
         if ((nxt == FETCH) && (cur != FETCH) && (cur != ERROR))
            retired <= retired + 1'b1;
      end
   end

   // The fetch writes complete in the same cycle the memory answers.
   assign irwrite  = ctrl.fetch & mem_ready;
   assign pcwrite  = ctrl.pcwrite | (ctrl.fetch & mem_ready);
   assign mem_req  = ctrl.mem_req;
   assign iord     = ctrl.iord;
   assign memwrite = ctrl.memwrite;
   assign branch   = ctrl.branch;
   assign alusrca  = ctrl.alusrca;
   assign regdst   = ctrl.regdst;
   assign memtoreg = ctrl.memtoreg;
   assign regwrite = ctrl.regwrite;
   assign alusrcb  = ctrl.alusrcb;
   assign pcsrc    = ctrl.pcsrc;
   assign aluop    = ctrl.aluop;
   assign err      = ctrl.err;
   assign state    = cur;

endmodule

// File: tb/tb_mc_controller.sv
// Bench for mc_controller: expected per-cycle output words are queued as each instruction is issued
// and popped as the DUT is sampled; retired/err are checked at instruction boundaries.
module tb_mc_controller;

   localparam logic [3:0] S_FETCH = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMREAD = 4'd3;
   localparam logic [3:0] S_MEMWB = 4'd4,  S_MEMWRITE = 4'd5, S_EXECUTE = 4'd6, S_ALUWB = 4'd7;
   localparam logic [3:0] S_BRANCH = 4'd8, S_ADDIEXEC = 4'd9, S_ADDIWB = 4'd10, S_JUMP = 4'd11;
   localparam logic [3:0] S_ERROR = 4'd12;

   localparam logic [5:0] OP_LW = 6'b100011, OP_SW = 6'b101011, OP_R = 6'b000000;
   localparam logic [5:0] OP_BEQ = 6'b000100, OP_ADDI = 6'b001000, OP_J = 6'b000010;
   localparam logic [5:0] OP_BAD = 6'b111111;

   logic       clk;
   logic       reset;
   logic [5:0] op;
   logic       mem_ready;
   logic       mem_req, iord, memwrite, irwrite, pcwrite, branch;
   logic       alusrca, regdst, memtoreg, regwrite, err;
   logic [1:0] alusrcb, pcsrc, aluop;
   logic [3:0] state;
   logic [3:0] retired;

   logic [20:0] exp_q[$];
   logic        rdy_q[$];
   int          tests_run;
   int          tests_failed;
   int unsigned exp_ret;

   mc_controller #(.TIMEOUT(15), .CNT_W(4)) dut (
      .clk(clk), .reset(reset), .op(op), .mem_ready(mem_ready),
      .mem_req(mem_req), .iord(iord), .memwrite(memwrite), .irwrite(irwrite),
      .pcwrite(pcwrite), .branch(branch), .alusrca(alusrca), .regdst(regdst),
      .memtoreg(memtoreg), .regwrite(regwrite), .alusrcb(alusrcb), .pcsrc(pcsrc),
      .aluop(aluop), .state(state), .err(err), .retired(retired)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [20:0] model(input logic [3:0] st, input logic rdy);
      logic mreq, io, mw, irw, pcw, br, asa, rd, m2r, rw, er;
      logic [1:0] asb, pcs, aop;
      {mreq, io, mw, irw, pcw, br, asa, rd, m2r, rw, er} = '0;
      {asb, pcs, aop} = '0;
      case (st)
         S_FETCH:    begin mreq = 1; asb = 2'b01; irw = rdy; pcw = rdy; end
         S_DECODE:   asb = 2'b11;
         S_MEMADR,
         S_ADDIEXEC: begin asa = 1; asb = 2'b10; end
         S_MEMREAD:  begin io = 1; mreq = 1; end
         S_MEMWRITE: begin io = 1; mreq = 1; mw = 1; end
         S_MEMWB:    begin m2r = 1; rw = 1; end
         S_ALUWB:    begin rd = 1; rw = 1; end
         S_ADDIWB:   rw = 1;
         S_EXECUTE:  begin asa = 1; aop = 2'b10; end
         S_BRANCH:   begin asa = 1; aop = 2'b01; pcs = 2'b01; br = 1; end
         S_JUMP:     begin pcs = 2'b10; pcw = 1; end
         S_ERROR:    er = 1;
         default:    ;
      endcase
      return {st, er, mreq, io, mw, irw, pcw, br, asa, rd, m2r, rw, asb, pcs, aop};
   endfunction

   task automatic expect_cycle(input logic [3:0] st, input logic rdy);
      exp_q.push_back(model(st, rdy));
      rdy_q.push_back(rdy);
   endtask

   // Drives one cycle per queued entry and compares the DUT word mid-cycle.
   task automatic run_queue(input logic [5:0] op_v, input string name);
      op = op_v;
      while (rdy_q.size() > 0) begin
         logic [20:0] exp_w;
         logic [20:0] act_w;
         mem_ready = rdy_q.pop_front();
         #2;
         exp_w = exp_q.pop_front();
         act_w = {state, err, mem_req, iord, memwrite, irwrite, pcwrite, branch,
                  alusrca, regdst, memtoreg, regwrite, alusrcb, pcsrc, aluop};
         tests_run++;
         if (act_w !== exp_w) begin
            tests_failed++;
            $display("FAIL %s: state/ctrl word got %h expected %h", name, act_w, exp_w);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic issue(input logic [5:0] op_v, input int fwait, input int mwait, input string name);
      for (int i = 0; i < fwait; i++) expect_cycle(S_FETCH, 1'b0);
      expect_cycle(S_FETCH, 1'b1);
      expect_cycle(S_DECODE, 1'b1);
      case (op_v)
         OP_LW: begin
            expect_cycle(S_MEMADR, 1'b1);
            for (int i = 0; i < mwait; i++) expect_cycle(S_MEMREAD, 1'b0);
            expect_cycle(S_MEMREAD, 1'b1);
            expect_cycle(S_MEMWB, 1'b1);
         end
         OP_SW: begin
            expect_cycle(S_MEMADR, 1'b1);
            for (int i = 0; i < mwait; i++) expect_cycle(S_MEMWRITE, 1'b0);
            expect_cycle(S_MEMWRITE, 1'b1);
         end
         OP_R:    begin expect_cycle(S_EXECUTE, 1'b1); expect_cycle(S_ALUWB, 1'b1); end
         OP_ADDI: begin expect_cycle(S_ADDIEXEC, 1'b1); expect_cycle(S_ADDIWB, 1'b1); end
         OP_BEQ:  expect_cycle(S_BRANCH, 1'b1);
         OP_J:    expect_cycle(S_JUMP, 1'b1);
         default: ;
      endcase
      run_queue(op_v, name);
      exp_ret = (exp_ret + 1) % 16;
   endtask

   task automatic apply_reset();
      reset = 1'b1;
      mem_ready = 1'b0;
      @(posedge clk); #1;
      exp_ret = 0;
   endtask

   task automatic test_reset();
      apply_reset();
      @(posedge clk); #1;
      tests_run++;
      if ({state, err, mem_req, alusrcb, retired} !== {S_FETCH, 1'b0, 1'b1, 2'b01, 4'd0}) begin
         tests_failed++;
         $display("FAIL reset_hold: st/err/req/asb/ret got %h expected %h",
                  {state, err, mem_req, alusrcb, retired}, {S_FETCH, 1'b0, 1'b1, 2'b01, 4'd0});
      end
      reset = 1'b0;
   endtask

   task automatic test_rtype();
      issue(OP_R, 0, 0, "rtype");
      tests_run++;
      if (retired !== 4'(exp_ret) || state !== S_FETCH) begin
         tests_failed++;
         $display("FAIL rtype_retired: retired %0d state %0d expected %0d/0", retired, state, exp_ret);
      end
   endtask

   task automatic test_memory();
      issue(OP_LW, 0, 3, "lw_wait");
      issue(OP_SW, 2, 2, "sw_wait");
      issue(OP_ADDI, 0, 0, "addi");
      issue(OP_BEQ, 1, 0, "beq");
      tests_run++;
      if (retired !== 4'(exp_ret)) begin
         tests_failed++;
         $display("FAIL memory_retired: got %0d expected %0d", retired, exp_ret);
      end
   endtask

   task automatic test_bad_op();
      expect_cycle(S_FETCH, 1'b1);
      expect_cycle(S_DECODE, 1'b1);
      for (int i = 0; i < 3; i++) expect_cycle(S_ERROR, 1'b1);
      run_queue(OP_BAD, "bad_op");
      tests_run++;
      if (retired !== 4'(exp_ret) || err !== 1'b1) begin
         tests_failed++;
         $display("FAIL bad_op_sticky: retired %0d err %b expected %0d/1", retired, err, exp_ret);
      end
      test_reset();
   endtask

   task automatic test_jump();
`ifdef MC_CONTROLLER_JUMP_EN
      issue(OP_J, 0, 0, "jump");
`else
      expect_cycle(S_FETCH, 1'b1);
      expect_cycle(S_DECODE, 1'b1);
      expect_cycle(S_ERROR, 1'b1);
      run_queue(OP_J, "jump_disabled");
`endif
      tests_run++;
      if (retired !== 4'(exp_ret)) begin
         tests_failed++;
         $display("FAIL jump_retired: got %0d expected %0d", retired, exp_ret);
      end
      test_reset();
   endtask

   task automatic test_timeout();
      issue(OP_BEQ, 15, 0, "timeout_edge_ready_wins");
      for (int i = 0; i < 10; i++) expect_cycle(S_FETCH, 1'b0);
      run_queue(OP_BEQ, "mid_wait");
      test_reset();
      issue(OP_BEQ, 15, 0, "wait_cleared_by_reset");
      for (int i = 0; i < 16; i++) expect_cycle(S_FETCH, 1'b0);
      expect_cycle(S_ERROR, 1'b0);
      expect_cycle(S_ERROR, 1'b1);
      run_queue(OP_R, "timeout");
      tests_run++;
      if (err !== 1'b1 || retired !== 4'(exp_ret)) begin
         tests_failed++;
         $display("FAIL timeout_err: err %b retired %0d expected 1/%0d", err, retired, exp_ret);
      end
      test_reset();
   endtask

   task automatic test_wrap();
      for (int i = 0; i < 16; i++) begin
         issue(OP_BEQ, $urandom_range(0, 2), 0, "wrap_beq");
         if (i >= 14) begin
            tests_run++;
            if (retired !== ((i == 14) ? 4'd15 : 4'd0)) begin
               tests_failed++;
               $display("FAIL wrap: after %0d beq retired %0d", i + 1, retired);
            end
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [5:0] ops[5];
      ops[0] = OP_LW; ops[1] = OP_SW; ops[2] = OP_R; ops[3] = OP_BEQ; ops[4] = OP_ADDI;
      for (int i = 0; i < 10; i++) begin
         issue(ops[$urandom_range(0, 4)], $urandom_range(0, 4), $urandom_range(0, 4), "b2b");
         tests_run++;
         if (retired !== 4'(exp_ret) || state !== S_FETCH) begin
            tests_failed++;
            $display("FAIL b2b_retired: retired %0d state %0d expected %0d/0", retired, state, exp_ret);
         end
      end
   endtask

   initial begin
      tests_run = 0;
      tests_failed = 0;
      exp_ret = 0;
      reset = 1'b1;
      op = OP_R;
      mem_ready = 1'b0;
      test_reset();
      test_rtype();
      test_memory();
      test_bad_op();
      test_jump();
      test_timeout();
      test_wrap();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
